// File: rtl/hp_fp_add_issue.sv
// hp_fp_add_issue: operand issue / result collection around a free-running FP16 adder core.
// Optional special-operand bypass is enabled by defining HP_FP_SPECIAL_BYPASS_EN.
`default_nettype none

module hp_fp_add_issue #(
  parameter int FIFO_DEPTH = 4,
  parameter int OUT_DEPTH  = 8,
  parameter int ADDER_LAT  = 4,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [15:0]      add_num1,
  output logic [15:0]      add_num2,
  input  logic [15:0]      add_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_sum,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int IAW = $clog2(FIFO_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int CW  = OAW + 1;
  localparam logic [IAW:0] IP_ONE = 1;
  localparam logic [OAW:0] OP_ONE = 1;
  localparam logic [CW-1:0] CR_ONE = 1;
  localparam logic [CW-1:0] CR_FULL = CW'(OUT_DEPTH);

  // Input operand FIFO
  logic [15:0]      ia_mem [FIFO_DEPTH];
  logic [15:0]      ib_mem [FIFO_DEPTH];
  logic [TAG_W-1:0] it_mem [FIFO_DEPTH];
  logic [IAW:0]     in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  logic             in_empty, in_full, push, issue;

  // Output result FIFO
  logic [15:0]      os_mem [OUT_DEPTH];
  logic [TAG_W-1:0] ot_mem [OUT_DEPTH];
  logic [OAW:0]     out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic             out_empty, pop, wb;
  logic [15:0]      wb_data;

  logic [CW-1:0]    credits_q, credits_d;
  logic [15:0]      num1_q, num2_q;

  logic [ADDER_LAT-1:0] pv_q;
  logic [TAG_W-1:0]     ptag_q [ADDER_LAT];

  assign in_empty = (in_wr_q == in_rd_q);
  assign in_full  = (in_wr_q[IAW] != in_rd_q[IAW]) &&
                    (in_wr_q[IAW-1:0] == in_rd_q[IAW-1:0]);
  assign in_ready = !in_full && !reset;
  assign push     = in_valid && in_ready;
  assign issue    = !in_empty && (credits_q != '0) && !reset;

  assign out_empty = (out_wr_q == out_rd_q);
  assign out_valid = !out_empty;
  assign pop       = out_valid && out_ready && !reset;
  assign wb        = pv_q[ADDER_LAT-1];
  assign out_sum   = out_empty ? 16'h0000 : os_mem[out_rd_q[OAW-1:0]];
  assign out_tag   = out_empty ? '0 : ot_mem[out_rd_q[OAW-1:0]];

  assign add_num1 = num1_q;
  assign add_num2 = num2_q;
  assign busy     = !in_empty || (|pv_q) || !out_empty;

  always_comb begin
    in_wr_d   = push  ? in_wr_q + IP_ONE : in_wr_q;
    in_rd_d   = issue ? in_rd_q + IP_ONE : in_rd_q;
    out_wr_d  = wb    ? out_wr_q + OP_ONE : out_wr_q;
    out_rd_d  = pop   ? out_rd_q + OP_ONE : out_rd_q;
    credits_d = credits_q;
    if (pop && !issue) credits_d = credits_q + CR_ONE;
    else if (issue && !pop) credits_d = credits_q - CR_ONE;
  end

`ifdef HP_FP_SPECIAL_BYPASS_EN
  logic [ADDER_LAT-1:0] pbyp_q;
  logic [15:0]          pbval_q [ADDER_LAT];
  logic [16:0]          cls;

  // Returns {bypass_flag, bypass_value} for an FP16 operand pair.
  function automatic logic [16:0] classify(input logic [15:0] a, input logic [15:0] b);
    logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    nan_a  = (a[14:10] == 5'h1F) && (a[9:0] != 10'h000);
    nan_b  = (b[14:10] == 5'h1F) && (b[9:0] != 10'h000);
    inf_a  = (a[14:10] == 5'h1F) && (a[9:0] == 10'h000);
    inf_b  = (b[14:10] == 5'h1F) && (b[9:0] == 10'h000);
    zero_a = (a[14:0] == 15'h0000);
    zero_b = (b[14:0] == 15'h0000);
    if (nan_a || nan_b)                      classify = {1'b1, 16'h7E00};
    else if (inf_a && inf_b && (a[15] != b[15])) classify = {1'b1, 16'h7E00};
    else if (inf_a)                          classify = {1'b1, a};
    else if (inf_b)                          classify = {1'b1, b};
    else if (zero_a && zero_b)               classify = {1'b1, (a[15] && b[15]) ? 16'h8000 : 16'h0000};
    else if (zero_a)                         classify = {1'b1, b};
    else if (zero_b)                         classify = {1'b1, a};
    else                                     classify = {1'b0, 16'h0000};
  endfunction

  assign cls     = classify(ia_mem[in_rd_q[IAW-1:0]], ib_mem[in_rd_q[IAW-1:0]]);
  assign wb_data = pbyp_q[ADDER_LAT-1] ? pbval_q[ADDER_LAT-1] : add_sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      pbyp_q <= '0;
      for (int i = 0; i < ADDER_LAT; i++) pbval_q[i] <= 16'h0000;
    end else begin
      pbyp_q[0]  <= issue && cls[16];
      pbval_q[0] <= cls[15:0];
      for (int i = 1; i < ADDER_LAT; i++) begin
        pbyp_q[i]  <= pbyp_q[i-1];
        pbval_q[i] <= pbval_q[i-1];
      end
    end
  end
`else
  assign wb_data = add_sum;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      ia_mem[in_wr_q[IAW-1:0]] <= in_a;
      ib_mem[in_wr_q[IAW-1:0]] <= in_b;
      it_mem[in_wr_q[IAW-1:0]] <= in_tag;
    end
    if (wb && !reset) begin
      os_mem[out_wr_q[OAW-1:0]] <= wb_data;
      ot_mem[out_wr_q[OAW-1:0]] <= ptag_q[ADDER_LAT-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_wr_q   <= '0;
      in_rd_q   <= '0;
      out_wr_q  <= '0;
      out_rd_q  <= '0;
      credits_q <= CR_FULL;
      num1_q    <= 16'h0000;
      num2_q    <= 16'h0000;
      pv_q      <= '0;
      for (int i = 0; i < ADDER_LAT; i++) ptag_q[i] <= '0;
    end else begin
      in_wr_q   <= in_wr_d;
      in_rd_q   <= in_rd_d;
      out_wr_q  <= out_wr_d;
      out_rd_q  <= out_rd_d;
      credits_q <= credits_d;
      // Idle cycles drive zeros into the core and a bubble into the tracking pipe
      num1_q    <= issue ? ia_mem[in_rd_q[IAW-1:0]] : 16'h0000;
      num2_q    <= issue ? ib_mem[in_rd_q[IAW-1:0]] : 16'h0000;
      pv_q[0]   <= issue;
      ptag_q[0] <= it_mem[in_rd_q[IAW-1:0]];
      for (int i = 1; i < ADDER_LAT; i++) begin
        pv_q[i]   <= pv_q[i-1];
        ptag_q[i] <= ptag_q[i-1];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hp_fp_add_issue.sv
// Testbench for hp_fp_add_issue: integer delay-model adder core, queue scoreboard, directed + random steps.
`default_nettype none

module tb_hp_fp_add_issue;

  localparam int FIFO_DEPTH = 4;
  localparam int OUT_DEPTH  = 8;
  localparam int ADDER_LAT  = 4;
  localparam int TAG_W      = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready;
  logic [15:0]      in_a, in_b;
  logic [TAG_W-1:0] in_tag;
  logic [15:0]      add_num1, add_num2, add_sum;
  logic             out_valid, out_ready;
  logic [15:0]      out_sum;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  always #5 clk = ~clk;

  hp_fp_add_issue #(
    .FIFO_DEPTH(FIFO_DEPTH), .OUT_DEPTH(OUT_DEPTH), .ADDER_LAT(ADDER_LAT), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .add_num1(add_num1), .add_num2(add_num2), .add_sum(add_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_tag(out_tag),
    .busy(busy)
  );

  // Adder core stand-in: sum appears ADDER_LAT cycles after the operand registers update
  logic [15:0] core_q [ADDER_LAT-1];
  always @(posedge clk) begin
    core_q[0] <= add_num1 + add_num2;
    for (int j = 1; j < ADDER_LAT-1; j++) core_q[j] <= core_q[j-1];
  end
  assign add_sum = core_q[ADDER_LAT-2];

  typedef struct { logic [15:0] sum; logic [TAG_W-1:0] tag; } res_t;
  res_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int pops = 0;
  int first_pop_cyc = -1;
  int last_pop_cyc = 0;
  bit accepted;

  function automatic logic [15:0] ref_sum(input logic [15:0] a, input logic [15:0] b);
`ifdef HP_FP_SPECIAL_BYPASS_EN
    bit nan_a, nan_b, inf_a, inf_b, z_a, z_b;
    nan_a = (a[14:10] == 5'h1F) && (a[9:0] != 0);
    nan_b = (b[14:10] == 5'h1F) && (b[9:0] != 0);
    inf_a = (a[14:10] == 5'h1F) && (a[9:0] == 0);
    inf_b = (b[14:10] == 5'h1F) && (b[9:0] == 0);
    z_a   = (a[14:0] == 0);
    z_b   = (b[14:0] == 0);
    if (nan_a || nan_b) return 16'h7E00;
    if (inf_a && inf_b && a[15] != b[15]) return 16'h7E00;
    if (inf_a) return a;
    if (inf_b) return b;
    if (z_a && z_b) return (a[15] && b[15]) ? 16'h8000 : 16'h0000;
    if (z_a) return b;
    if (z_b) return a;
`endif
    return a + b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Sample handshakes mid-cycle, then advance one clock.
  task automatic step();
    res_t r;
    #1;
    accepted = 1'b0;
    if (!reset) begin
      if (out_valid && out_ready) begin
        chk("pop_has_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          r = exp_q.pop_front();
          chk("out_sum", 32'(out_sum), 32'(r.sum));
          chk("out_tag", 32'(out_tag), 32'(r.tag));
          pops++;
          if (first_pop_cyc < 0) first_pop_cyc = cycle;
          last_pop_cyc = cycle;
        end
      end
      if (in_valid && in_ready) begin
        r.sum = ref_sum(in_a, in_b);
        r.tag = in_tag;
        exp_q.push_back(r);
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cycle++;
    chk("credits_range", 32'(dut.credits_q <= OUT_DEPTH), 32'd1);
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [TAG_W-1:0] t);
    int n;
    in_valid = 1'b1; in_a = a; in_b = b; in_tag = t;
    n = 0;
    do begin step(); n++; end while (!accepted && n < 200);
    chk("push_accepted", 32'(accepted), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 500) begin step(); n++; end
    chk("drain_done", 32'(n < 500), 32'd1);
  endtask

  initial begin
    int n, p0, n_acc;
    bit seen;
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
    step(); step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_add_num1", 32'(add_num1), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Single op; pushed in cycle 0, out_valid expected in cycle 2+ADDER_LAT
    out_ready = 1'b1;
    push(16'h0001, 16'h0002, 4'd3);
    n = 0;
    while (!out_valid && n < 50) begin step(); n++; end
    chk("single_latency", 32'(n), 32'(ADDER_LAT + 1));
    chk("single_sum", 32'(out_sum), 32'h0003);
    chk("single_tag", 32'(out_tag), 32'd3);
    drain();
    chk("single_busy_idle", 32'(busy), 32'd0);

    // Back-to-back stream, results must be gapless
    p0 = pops; first_pop_cyc = -1;
    for (int i = 0; i < 16; i++) push(16'(i), 16'h0100, 4'(i));
    drain();
    chk("b2b_count", 32'(pops - p0), 32'd16);
    chk("b2b_nogap", 32'(last_pop_cyc - first_pop_cyc), 32'd15);

    // Backpressure: downstream stalled, capacity is output FIFO plus input FIFO
    out_ready = 1'b0;
    p0 = pops;
    n_acc = 0;
    for (int i = 0; i < 20 && n_acc < OUT_DEPTH + FIFO_DEPTH; i++) begin
      push(16'h1000 + 16'(i), 16'(i), 4'(i));
      n_acc++;
    end
    in_valid = 1'b1; in_a = 16'h1000 + 16'(n_acc); in_b = 16'(n_acc); in_tag = 4'(n_acc);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin step(); if (accepted) seen = 1'b1; end
    chk("bp_no_extra_accept", 32'(seen), 32'd0);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_out_held", 32'(out_valid), 32'd1);
    chk("bp_held_count", 32'(exp_q.size()), 32'(OUT_DEPTH + FIFO_DEPTH));
    chk("bp_no_pops", 32'(pops - p0), 32'd0);
    out_ready = 1'b1;
    for (int i = n_acc; i < 20; i++) push(16'h1000 + 16'(i), 16'(i), 4'(i));
    drain();
    chk("bp_total", 32'(pops - p0), 32'd20);

    // Reset with operations in flight
    for (int i = 0; i < 3; i++) push(16'h2000 + 16'(i), 16'h0001, 4'(i));
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < ADDER_LAT + 4; k++) begin step(); if (out_valid) seen = 1'b1; end
    chk("mid_rst_no_stale", 32'(seen), 32'd0);
    p0 = pops;
    push(16'h0005, 16'h0006, 4'd9);
    drain();
    chk("mid_rst_one_result", 32'(pops - p0), 32'd1);

    // Special operands; expectations follow the build's classification rules
    chk("ref_inf_pair", 32'(ref_sum(16'h7C00, 16'hFC00)),
`ifdef HP_FP_SPECIAL_BYPASS_EN
        32'h7E00);
`else
        32'h7800);
`endif
    push(16'h7C00, 16'hFC00, 4'd1);
    push(16'h0000, 16'h3C00, 4'd2);
    push(16'h8000, 16'h8000, 4'd3);
    push(16'h7E01, 16'h3C00, 4'd4);
    drain();

    // Random valid/ready traffic
    p0 = pops;
    n_acc = 0;
    n = 0;
    in_valid = 1'b0;
    while (n_acc < 1000 && n < 20000) begin
      if (!in_valid || accepted) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_a = 16'($urandom);
        in_b = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
        in_tag = 4'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      step();
      if (accepted) n_acc++;
      n++;
    end
    in_valid = 1'b0;
    drain();
    chk("rand_accepted", 32'(n_acc), 32'd1000);
    chk("rand_popped", 32'(pops - p0), 32'd1000);
    chk("final_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hp_fp_add_issue.md
Name: hp_fp_add_issue

Overview:
Operand issue and result collection stage wrapped around the 3-stage half-precision FP adder core.
- Accepts tagged operand pairs over a valid/ready interface and buffers them.
- Drives the free-running adder core, which has no stall input, one pair per cycle at most.
- Tracks in-flight operations with a latency-matched valid/tag pipe and captures each sum into an output FIFO.
- Uses credit-based issue so no result is ever dropped under downstream backpressure.

Parameters:
FIFO_DEPTH, 4, input operand FIFO entries (power of 2, >=2)
OUT_DEPTH, 8, output result FIFO entries (power of 2, must be >= ADDER_LAT)
ADDER_LAT, 4, cycles from add_num1/add_num2 register update to matching add_sum valid at this block's input
TAG_W, 4, width of user tag carried alongside each operation

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  operand pair valid
in_ready  out  1  input FIFO not full
in_a  in  16  operand A, IEEE half
in_b  in  16  operand B, IEEE half
in_tag  in  TAG_W  user tag
add_num1  out  16  registered operand to adder core
add_num2  out  16  registered operand to adder core
add_sum  in  16  sum from adder core
out_valid  out  1  result FIFO not empty
out_ready  in  1  downstream accepts result
out_sum  out  16  result at FIFO head
out_tag  out  TAG_W  tag at FIFO head
busy  out  1  any entry in input FIFO, in flight, or in output FIFO

Behaviour:
- Reset (clk, reset synchronous active-high): all outputs 0; in_ready=0 only during the reset cycle and 1 on the first cycle after; FIFOs empty, credits=OUT_DEPTH, valid pipe cleared.
- Reset mid-operation discards all queued, in-flight and unread results; add_sum arriving afterwards is ignored.
- Input push: in_valid && in_ready, with in_ready = !in_full.
- Push into a full FIFO is impossible because in_ready=0.
- Push and pop in the same cycle are both performed; count is unchanged.
- Credits: credits = OUT_DEPTH - out_count - inflight, held as a counter.
  - Decrement on issue; increment on output pop.
  - Issue and pop in the same cycle leave credits unchanged.
- Issue: when input FIFO is non-empty and credits > 0:
  - pop the FIFO head and register add_num1 = a, add_num2 = b;
  - shift {1, tag} into the valid/tag pipe.
- No issue in a cycle: add_num1 = add_num2 = 16'h0000 and a 0 is shifted into the valid pipe.
- Maximum throughput is 1 issue per cycle.
- Valid/tag pipe is ADDER_LAT deep. When its tail is valid, add_sum and the tail tag are written into the output FIFO that cycle.
  - Credits guarantee the output FIFO has room.
- Output: out_valid = !out_empty. Pop on out_valid && out_ready.
  - out_sum/out_tag are stable while out_valid && !out_ready.
- Ordering: results leave strictly in acceptance order.
- Latency with empty FIFOs and out_ready=1:
  - push at edge k, issue registered at edge k+1;
  - result written at edge k+1+ADDER_LAT;
  - out_valid high in the cycle after that edge.
- Pointer wrap-around: pointers are log2(depth)+1 bits; full/empty are decided by comparing the MSBs.
- busy = !in_empty || (inflight != 0) || !out_empty.

Optional Feature:
Macro: HP_FP_SPECIAL_BYPASS_EN
- Defined: at issue, each pair is classified and a 16-bit bypass value plus a bypass flag travel with the tag pipe. At writeback the bypass value replaces add_sum when the flag is set. Classification:
  - either operand NaN (exp=31, mant!=0) -> 16'h7E00;
  - +Inf + -Inf -> 16'h7E00;
  - one Inf -> that Inf;
  - one operand is ±0 (exp=0, mant=0) -> the other operand;
  - both ±0 -> 16'h0000 unless both are -0, which gives 16'h8000.
- Not defined: no classification logic; add_sum is always written unmodified.
- Timing and ordering are identical in both builds.

Test Plan:
Bench replaces the adder core with an ADDER_LAT delay model computing add_sum = add_num1 + add_num2 (16-bit integer wrap), so values are exact.
- Single op: a=16'h0001, b=16'h0002, tag=3, out_ready=1 -> out_sum=16'h0003, out_tag=3, out_valid first high 2+ADDER_LAT cycles after push; busy returns to 0.
- Back-to-back 16 ops with a=i, b=16'h0100, tags i mod 16, out_ready=1 -> one result per cycle after fill, out_sum=16'h0100+i in order, no gaps.
- Backpressure: out_ready=0 while 20 ops are pushed -> exactly OUT_DEPTH results are held, in_ready falls once the input FIFO fills, and no add_sum is dropped. Then out_ready=1 -> all 20 results emerge in order.
- Reset mid-stream with 3 ops in flight -> next cycle out_valid=0 and busy=0; a later op a=5, b=6 gives exactly one result, 16'h000B.
- Random valid/ready toggling over 1000 ops -> scoreboard matches every result in order, and credits never go negative or above OUT_DEPTH.
- HP_FP_SPECIAL_BYPASS_EN build:
  - 16'h7C00 + 16'hFC00 -> 16'h7E00;
  - 16'h0000 + 16'h3C00 -> 16'h3C00;
  - 16'h8000 + 16'h8000 -> 16'h8000;
  - without the macro, the same inputs give the integer model sums.
